// File: rtl/bus_pkg.sv
// Shared definitions for the bus endpoint: ID width, broadcast ID and
// destination-field extraction.
package bus_pkg;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned PKT_MAX_W = 256;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    // Destination ID: the top ID_W bits of a pkt_w-bit packet (zero-extended into pkt)
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned        pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

endpackage

// File: rtl/bus_ep_fifo.sv
// First-word-fall-through FIFO. A write while full is taken only when a read
// frees the head slot in the same cycle; the head reads 0 while empty.
module bus_ep_fifo
    import bus_pkg::*;
#(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    // Status decoded from the registered count only
    assign full  = (count == CNT_W'(depth));
    assign empty = (count == '0);

    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    assign rdata = empty ? '0 : mem[rptr];

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_W'(1);
            if (do_rd) rptr <= rptr + PTR_W'(1);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // Storage; contents are don't-care after reset because the head is gated by empty
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/bus_endpoint.sv
// Device-side bus endpoint: TX FIFO toward the bus, RX FIFO from the bus,
// optional destination filter, sticky RX overflow flag and drop counter.
// Define BUS_EP_ADDR_FILTER_EN to enable the destination address filter.
module bus_endpoint
    import bus_pkg::*;
#(
    parameter int unsigned      pckg_sz   = 16,
    parameter int unsigned      depth     = 8,
    parameter logic [ID_W-1:0]  id        = 8'd0,
    parameter logic [ID_W-1:0]  broadcast = BROADCAST_ID
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd,
    output logic               rx_ovf,
    output logic [7:0]         rx_drop_cnt
);

`ifdef BUS_EP_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam int unsigned DROP_W = 8;

    logic            tx_empty;
    logic            rx_empty;
    logic            rx_full;
    logic [ID_W-1:0] dest;
    logic            addr_match;
    logic            accept;
    logic            rx_reading;

    assign dest       = dest_of(PKT_MAX_W'(D_push), pckg_sz);
    assign addr_match = (dest == id) || (dest == broadcast);
    assign accept     = ~FILTER_EN | addr_match;
    assign rx_reading = rx_rd & ~rx_empty;

    assign pndng    = ~tx_empty;
    assign rx_valid = ~rx_empty;

    // Outbound queue; a write while full is refused even if the bus pops
    bus_ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr & ~tx_full),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Inbound queue; a read in the same cycle makes room for a push while full
    bus_ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push & accept),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Sticky overflow: an accepted push found no room
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ovf <= 1'b0;
        end else if (push && accept && rx_full && !rx_reading) begin
            rx_ovf <= 1'b1;
        end
    end

    // Saturating count of pushes rejected by the address filter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_drop_cnt <= '0;
        end else if (FILTER_EN && push && !addr_match && (rx_drop_cnt != {DROP_W{1'b1}})) begin
            rx_drop_cnt <= rx_drop_cnt + DROP_W'(1);
        end
    end

endmodule
